fp_to_decimal_core: RTL and testbench

//  Converts an IEEE-754 single-precision word into decimal-display fields:

---
 rtl/fp_to_decimal_core_if.sv | 40 ++++
 rtl/fp_to_decimal_core.sv | 158 +++++++++++++++
 tb/tb_fp_to_decimal_core.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/fp_to_decimal_core_if.sv
// -----------------------------------------------------------------------------
// fp_to_decimal_core_if
//   Bundles the request and result fields of the float-to-decimal conversion
//   core.
//   master : the producer of IEEE-754 words and the consumer of the results
//   slave  : the conversion core itself
//   Signals
//     in_valid, fp_in              request (fp_in is sampled while in_valid=1)
//     out_valid                    result fields are valid this cycle
//     sign_char, exp_sign_char     ASCII '+'/'-' for the value and exponent
//     shift_amt                    |exp - 127|
//     int_part, frac_bits          integer part and binary fraction of |value|
//     frac_dec                     decimal fraction, 0..999999
//     ovf, special                 integer overflow / zero-denormal-inf-NaN
// -----------------------------------------------------------------------------
interface fp_to_decimal_core_if;
  logic        in_valid;
  logic [31:0] fp_in;
  logic        out_valid;
  logic [7:0]  sign_char;
  logic [7:0]  exp_sign_char;
  logic [7:0]  shift_amt;
  logic [23:0] int_part;
  logic [22:0] frac_bits;
  logic [22:0] frac_dec;
  logic        ovf;
  logic        special;

  modport master (
    output in_valid, fp_in,
    input  out_valid, sign_char, exp_sign_char, shift_amt,
           int_part, frac_bits, frac_dec, ovf, special
  );

  modport slave (
    input  in_valid, fp_in,
    output out_valid, sign_char, exp_sign_char, shift_amt,
           int_part, frac_bits, frac_dec, ovf, special
  );
endinterface

// File: rtl/fp_to_decimal_core.sv
// -----------------------------------------------------------------------------
// fp_to_decimal_core
//   Splits an IEEE-754 single-precision word into the fields used by the
//   decimal formatter: sign character, exponent sign and magnitude, 24-bit
//   integer part, 23-bit binary fraction and a FRAC_DIGITS-digit decimal
//   fraction. Two register stages: stage 1 aligns the mantissa, stage 2
//   scales the binary fraction to decimal. One conversion per cycle, no
//   back-pressure; result fields hold their last value while out_valid=0.
//   Ports
//     clk    : rising-edge clock
//     rst_n  : asynchronous active-low reset, clears all state
//     bus    : fp_to_decimal_core_if.slave (request and result fields)
//   Parameters
//     FRAC_DIGITS : decimal fraction digits, frac_dec = floor(frac * 10^N);
//                   at most 6 so the result fits the 23-bit field.
// -----------------------------------------------------------------------------
module fp_to_decimal_core #(
  parameter int FRAC_DIGITS = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fp_to_decimal_core_if.slave  bus
);

  localparam logic [7:0]  CHAR_PLUS  = 8'h2B;
  localparam logic [7:0]  CHAR_MINUS = 8'h2D;
  localparam logic [63:0] POW10      = 64'(10 ** FRAC_DIGITS);

  // ---------------------------------------------------------------------------
  // Stage 1: exponent decode and mantissa alignment
  // ---------------------------------------------------------------------------
  logic [7:0]  exp_f;
  logic [23:0] mant_full;
  logic        e_nonneg;
  logic        is_special;
  logic        too_big;

  logic [7:0]  s1_sign_d,  s1_esign_d, s1_shift_d;
  logic [23:0] s1_int_d;
  logic [22:0] s1_frac_d;
  logic        s1_ovf_d;

  assign exp_f      = bus.fp_in[30:23];
  assign mant_full  = {1'b1, bus.fp_in[22:0]};
  assign e_nonneg   = (exp_f >= 8'd127);
  assign is_special = (exp_f == 8'd0) || (exp_f == 8'hFF);

  assign s1_sign_d  = bus.fp_in[31] ? CHAR_MINUS : CHAR_PLUS;
  assign s1_esign_d = e_nonneg ? CHAR_PLUS : CHAR_MINUS;
  assign s1_shift_d = e_nonneg ? (exp_f - 8'd127) : (8'd127 - exp_f);
  assign too_big    = e_nonneg && (s1_shift_d > 8'd23);

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    s1_int_d  = '0;
    s1_frac_d = '0;
    s1_ovf_d  = 1'b0;
    // Specials (zero, denormal, inf, NaN) report zero magnitude and no ovf.
    if (!is_special) begin
      if (too_big) begin
        s1_ovf_d = 1'b1;
        s1_int_d = '1;
      end else if (e_nonneg) begin
        // 1.m placed at bit 23 of a 47-bit word, shifted left by E:
        // integer part lands in [46:23], fraction in [22:0].
        s1_int_d  = 24'((47'(mant_full) << s1_shift_d) >> 23);
        s1_frac_d = 23'(47'(mant_full) << s1_shift_d);
      end else if (s1_shift_d < 8'd24) begin
        // Value below one: the leading 1 moves right of the binary point;
        // bits shifted past 2^-23 are truncated.
        s1_frac_d = 23'(({mant_full, 23'b0} >> s1_shift_d) >> 23);
      end
    end
  end

  logic        s1_valid_q;
  logic [7:0]  s1_sign_q, s1_esign_q, s1_shift_q;
  logic [23:0] s1_int_q;
  logic [22:0] s1_frac_q;
  logic        s1_ovf_q, s1_special_q;

  // NOTE: clocked state is written with non-blocking assignments so every
  // register samples the pre-edge value of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_sign_q    <= '0;
      s1_esign_q   <= '0;
      s1_shift_q   <= '0;
      s1_int_q     <= '0;
      s1_frac_q    <= '0;
      s1_ovf_q     <= 1'b0;
      s1_special_q <= 1'b0;
    end else begin
      s1_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        s1_sign_q    <= s1_sign_d;
        s1_esign_q   <= s1_esign_d;
        s1_shift_q   <= s1_shift_d;
        s1_int_q     <= s1_int_d;
        s1_frac_q    <= s1_frac_d;
        s1_ovf_q     <= s1_ovf_d;
        s1_special_q <= is_special;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: binary fraction to decimal, floor(frac_bits * 10^N / 2^23).
  // The 43-bit product is formed at 64 bits; the quotient is always < 10^N.
  // ---------------------------------------------------------------------------
  logic [22:0] frac_dec_d;
  assign frac_dec_d = 23'((64'(s1_frac_q) * POW10) >> 23);

  logic        out_valid_q;
  logic [7:0]  sign_q, esign_q, shift_q;
  logic [23:0] int_q;
  logic [22:0] frac_q, frac_dec_q;
  logic        ovf_q, special_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sign_q      <= '0;
      esign_q     <= '0;
      shift_q     <= '0;
      int_q       <= '0;
      frac_q      <= '0;
      frac_dec_q  <= '0;
      ovf_q       <= 1'b0;
      special_q   <= 1'b0;
    end else begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        sign_q     <= s1_sign_q;
        esign_q    <= s1_esign_q;
        shift_q    <= s1_shift_q;
        int_q      <= s1_int_q;
        frac_q     <= s1_frac_q;
        frac_dec_q <= frac_dec_d;
        ovf_q      <= s1_ovf_q;
        special_q  <= s1_special_q;
      end
    end
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.sign_char     = sign_q;
  assign bus.exp_sign_char = esign_q;
  assign bus.shift_amt     = shift_q;
  assign bus.int_part      = int_q;
  assign bus.frac_bits     = frac_q;
  assign bus.frac_dec      = frac_dec_q;
  assign bus.ovf           = ovf_q;
  assign bus.special       = special_q;

endmodule

// File: tb/tb_fp_to_decimal_core.sv
// -----------------------------------------------------------------------------
// tb_fp_to_decimal_core
//   Self-checking bench for fp_to_decimal_core: a table of hand-computed
//   vectors, randomized words checked against a real-arithmetic model, and an
//   asynchronous reset in the middle of a stream. A monitor on the falling
//   edge expects each result exactly two rising edges after it was sampled
//   and expects the fields to hold while out_valid is low.
// -----------------------------------------------------------------------------
module tb_fp_to_decimal_core;

  localparam logic [7:0] P = 8'h2B;  // '+'
  localparam logic [7:0] M = 8'h2D;  // '-'

  typedef struct packed {
    logic [7:0]  sign_c;
    logic [7:0]  esign_c;
    logic [7:0]  shift;
    logic [23:0] ip;
    logic [22:0] fb;
    logic [22:0] fd;
    logic        ovf;
    logic        spec;
  } res_t;

  typedef struct packed {
    logic [31:0] fp;
    res_t        r;
  } vec_t;

  typedef struct packed {
    res_t r;
    int   tag;
  } pend_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fp_to_decimal_core_if bus ();

  fp_to_decimal_core #(.FRAC_DIGITS(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc   = 0;
  pend_t q[$];
  res_t  last;
  bit    mon_en = 1'b0;
  vec_t  tv[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_fields(input string tag, input res_t e);
    check({tag, ".sign_char"},     64'(bus.sign_char),     64'(e.sign_c));
    check({tag, ".exp_sign_char"}, 64'(bus.exp_sign_char), 64'(e.esign_c));
    check({tag, ".shift_amt"},     64'(bus.shift_amt),     64'(e.shift));
    check({tag, ".int_part"},      64'(bus.int_part),      64'(e.ip));
    check({tag, ".frac_bits"},     64'(bus.frac_bits),     64'(e.fb));
    check({tag, ".frac_dec"},      64'(bus.frac_dec),      64'(e.fd));
    check({tag, ".ovf"},           64'(bus.ovf),           64'(e.ovf));
    check({tag, ".special"},       64'(bus.special),       64'(e.spec));
  endtask

  // Reference: value = 1.m * 2^E evaluated in real arithmetic, then split.
  function automatic res_t model(input logic [31:0] fp);
    res_t r;
    int   e;
    real  mag, ipart;
    r         = '0;
    e         = int'(fp[30:23]) - 127;
    r.sign_c  = fp[31] ? M : P;
    r.esign_c = (e >= 0) ? P : M;
    r.shift   = 8'((e < 0) ? -e : e);
    if (fp[30:23] == 8'd0 || fp[30:23] == 8'd255) begin
      r.spec = 1'b1;
    end else if (e > 23) begin
      r.ovf = 1'b1;
      r.ip  = '1;
    end else begin
      mag   = (1.0 + real'(fp[22:0]) / 8388608.0) * (2.0 ** real'(e));
      ipart = $floor(mag);
      r.ip  = 24'($rtoi(ipart));
      r.fb  = 23'($rtoi($floor((mag - ipart) * 8388608.0)));
      r.fd  = 23'((longint'(r.fb) * 64'd1000000) / 64'd8388608);
    end
    return r;
  endfunction

  function automatic vec_t mk(input logic [31:0] fp, input logic [7:0] s, input logic [7:0] es,
                              input logic [7:0] sh, input logic [23:0] ip, input logic [22:0] fb,
                              input logic [22:0] fd, input logic ovf, input logic spec);
    vec_t v;
    v.fp = fp;
    v.r  = '{sign_c: s, esign_c: es, shift: sh, ip: ip, fb: fb, fd: fd, ovf: ovf, spec: spec};
    return v;
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0] ex;
    if ($urandom_range(1) == 0) ex = 8'($urandom_range(255));
    else                        ex = 8'($urandom_range(160, 95));
    return {1'($urandom_range(1)), ex, 23'($urandom)};
  endfunction

  task automatic send_exp(input logic [31:0] fp, input res_t r);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.fp_in    = fp;
    q.push_back('{r: r, tag: cyc + 1});
  endtask

  task automatic send(input logic [31:0] fp);
    send_exp(fp, model(fp));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.fp_in    = $urandom;
    end
  endtask

  // Monitor: a word sampled at rising edge T must be visible between edges
  // T+1 and T+2; at any other time out_valid is low and fields hold.
  initial begin
    pend_t p;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (q.size() > 0 && q[0].tag + 1 == cyc) begin
          p = q.pop_front();
          check("out_valid", 64'(bus.out_valid), 64'd1);
          check_fields("out", p.r);
          last = p.r;
        end else begin
          check("idle.out_valid", 64'(bus.out_valid), 64'd0);
          check_fields("hold", last);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tv.push_back(mk(32'hC6780000, M, P, 8'd13,  24'd15872,  23'h000000, 23'd0,      1'b0, 1'b0));
    tv.push_back(mk(32'h41708000, P, P, 8'd3,   24'd15,     23'h040000, 23'd31250,  1'b0, 1'b0));
    tv.push_back(mk(32'hBE400000, M, M, 8'd3,   24'd0,      23'h180000, 23'd187500, 1'b0, 1'b0));
    tv.push_back(mk(32'h3F800000, P, P, 8'd0,   24'd1,      23'h000000, 23'd0,      1'b0, 1'b0));
    tv.push_back(mk(32'hC1560000, M, P, 8'd3,   24'd13,     23'h300000, 23'd375000, 1'b0, 1'b0));
    tv.push_back(mk(32'h4F800000, P, P, 8'd32,  24'hFFFFFF, 23'h000000, 23'd0,      1'b1, 1'b0));
    tv.push_back(mk(32'h7F800000, P, P, 8'd128, 24'd0,      23'h000000, 23'd0,      1'b0, 1'b1));
    tv.push_back(mk(32'h00000000, P, M, 8'd127, 24'd0,      23'h000000, 23'd0,      1'b0, 1'b1));
    tv.push_back(mk(32'h80000000, M, M, 8'd127, 24'd0,      23'h000000, 23'd0,      1'b0, 1'b1));
    tv.push_back(mk(32'h7FC00000, P, P, 8'd128, 24'd0,      23'h000000, 23'd0,      1'b0, 1'b1));
    tv.push_back(mk(32'h4B7FFFFF, P, P, 8'd23,  24'hFFFFFF, 23'h000000, 23'd0,      1'b0, 1'b0));
    tv.push_back(mk(32'h4B800000, P, P, 8'd24,  24'hFFFFFF, 23'h000000, 23'd0,      1'b1, 1'b0));
    tv.push_back(mk(32'h33800000, P, M, 8'd24,  24'd0,      23'h000000, 23'd0,      1'b0, 1'b0));
    tv.push_back(mk(32'h34000000, P, M, 8'd23,  24'd0,      23'h000001, 23'd0,      1'b0, 1'b0));
    tv.push_back(mk(32'h3F7FFFFF, P, M, 8'd1,   24'd0,      23'h7FFFFF, 23'd999999, 1'b0, 1'b0));

    bus.in_valid = 1'b0;
    bus.fp_in    = '0;
    last         = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset.out_valid", 64'(bus.out_valid), 64'd0);
    check_fields("reset", '0);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Table vectors back to back, then a few bubbles.
    foreach (tv[i]) send_exp(tv[i].fp, tv[i].r);
    idle(3);

    // Randomized words with random bubbles.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) idle(1);
      else                        send(rand_fp());
    end
    idle(4);
    check("drain1.pending", 64'(q.size()), 64'd0);

    // Asynchronous reset in the middle of a stream: fields clear at once and
    // words accepted before the reset never emerge.
    send(32'h41708000);
    send(32'hC1560000);
    send(32'hBE400000);
    @(posedge clk);
    #2;
    mon_en       = 1'b0;
    bus.in_valid = 1'b0;
    check("pre_rst.out_valid", 64'(bus.out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst.out_valid", 64'(bus.out_valid), 64'd0);
    check_fields("async_rst", '0);
    q.delete();
    last = '0;
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    idle(5);

    // Stream resumes normally after reset.
    send(32'h3F800000);
    send(32'hC6780000);
    idle(4);
    check("drain2.pending", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
